ts_i2s_tx: RTL and testbench

//  Output stage behind the Turbosound-FM mixer. Latches the 12-bit L/R channel words once per audio frame.

---
 rtl/ts_i2s_tx_pkg.sv | 28 ++
 rtl/ts_i2s_tx_if.sv | 25 ++
 rtl/ts_i2s_clkgen.sv | 38 +++
 rtl/ts_i2s_tx.sv | 94 +++++++++
 tb/tb_ts_i2s_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_i2s_tx_pkg.sv
// Shared constants, channel type and sample conversion for the Turbosound-FM I2S output stage.
package ts_audio_pkg;

    localparam int IN_BITS    = 12;
    localparam int WORD_BITS  = 16;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int CNT_BITS   = $clog2(FRAME_BITS);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // Offset-binary inputs are flipped to two's complement before sign extension and gain.
    function automatic logic [WORD_BITS-1:0] conv_sample(
        input logic [IN_BITS-1:0] x,
        input logic               is_signed,
        input logic [2:0]         gain_shift
    );
        logic [IN_BITS-1:0]   s;
        logic [WORD_BITS-1:0] ext;
        s   = is_signed ? x : {~x[IN_BITS-1], x[IN_BITS-2:0]};
        ext = {{(WORD_BITS-IN_BITS){s[IN_BITS-1]}}, s};
        return ext << gain_shift;
    endfunction

endpackage

// File: rtl/ts_i2s_tx_if.sv
// Mixer-side sample inputs and DAC-side I2S outputs of the Turbosound-FM output stage.
interface ts_i2s_tx_if;
    import ts_audio_pkg::*;

    logic [IN_BITS-1:0] IN_L;
    logic [IN_BITS-1:0] IN_R;
    logic               IN_SIGNED;
    logic               MUTE;
    logic               SAMPLE_STB;
    logic               I2S_BCLK;
    logic               I2S_LRCK;
    logic               I2S_SDATA;

    // master = the transmitter generating the I2S clocks, slave = mixer/DAC side
    modport master (
        input  IN_L, IN_R, IN_SIGNED, MUTE,
        output SAMPLE_STB, I2S_BCLK, I2S_LRCK, I2S_SDATA
    );

    modport slave (
        output IN_L, IN_R, IN_SIGNED, MUTE,
        input  SAMPLE_STB, I2S_BCLK, I2S_LRCK, I2S_SDATA
    );

endinterface

// File: rtl/ts_i2s_clkgen.sv
// BCLK generator: divides the system clock and flags each BCLK falling transition.
module ts_i2s_clkgen #(
    parameter int CLK_HALF_DIV = 7
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic bclk_o,
    output logic fall_evt_o
);

    localparam int DIV_W = (CLK_HALF_DIV > 1) ? $clog2(CLK_HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == DIV_LAST);
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d    = bclk_q ^ wrap;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    // Combinational so the frame logic acts on the same edge that drops BCLK.
    assign bclk_o     = bclk_q;
    assign fall_evt_o = wrap & bclk_q;

endmodule

// File: rtl/ts_i2s_tx.sv
// Turbosound-FM output stage: latches L/R once per frame and serialises them as Philips I2S.
module ts_i2s_tx
    import ts_audio_pkg::*;
#(
    parameter int CLK_HALF_DIV = 7,
    parameter int GAIN_SHIFT   = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    ts_i2s_tx_if.master bus
);

    logic                 fall_evt;
    logic                 bclk;
    logic                 frame_start;
    logic [WORD_BITS-1:0] conv_l, conv_r, cur_word;

    logic [CNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
    chan_e                lrck_q, lrck_d;
    logic                 sdata_q, sdata_d;
    logic                 stb_q, stb_d;
    logic [WORD_BITS-1:0] hold_l_q, hold_l_d;
    logic [WORD_BITS-1:0] hold_r_q, hold_r_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;

    ts_i2s_clkgen #(
        .CLK_HALF_DIV (CLK_HALF_DIV)
    ) u_clkgen (
        .clk_i      (CLK),
        .rst_n_i    (RESET_N),
        .bclk_o     (bclk),
        .fall_evt_o (fall_evt)
    );

    // Slot 0 of each half is the I2S delay bit; slot 1 loads the word, later slots shift zeros out.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        shift_d     = shift_q;
        frame_start = fall_evt && (bit_cnt_q == CNT_BITS'(FRAME_BITS - 1));
        stb_d       = frame_start;
        conv_l      = bus.MUTE ? '0 : conv_sample(bus.IN_L, bus.IN_SIGNED, 3'(GAIN_SHIFT));
        conv_r      = bus.MUTE ? '0 : conv_sample(bus.IN_R, bus.IN_SIGNED, 3'(GAIN_SHIFT));
        cur_word    = '0;

        if (fall_evt) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            lrck_d    = chan_e'(bit_cnt_d[CNT_BITS-1]);
            cur_word  = (lrck_d == CH_RIGHT) ? hold_r_q : hold_l_q;
            if (frame_start) begin
                hold_l_d = conv_l;
                hold_r_d = conv_r;
            end
            if (bit_cnt_d[CNT_BITS-2:0] == '0) begin
                sdata_d = 1'b0;
            end else if (bit_cnt_d[CNT_BITS-2:0] == (CNT_BITS-1)'(1)) begin
                sdata_d = cur_word[WORD_BITS-1];
                shift_d = {cur_word[WORD_BITS-2:0], 1'b0};
            end else begin
                sdata_d = shift_q[WORD_BITS-1];
                shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt_q <= '0;
            lrck_q    <= CH_LEFT;
            sdata_q   <= 1'b0;
            stb_q     <= 1'b0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            shift_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
            sdata_q   <= sdata_d;
            stb_q     <= stb_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            shift_q   <= shift_d;
        end
    end

    assign bus.SAMPLE_STB = stb_q;
    assign bus.I2S_BCLK   = bclk;
    assign bus.I2S_LRCK   = lrck_q;
    assign bus.I2S_SDATA  = sdata_q;

endmodule

// File: tb/tb_ts_i2s_tx.sv
// Self-checking bench for ts_i2s_tx: a DAC-style decoder checks each frame against a scoreboard.
module tb_ts_i2s_tx;

    localparam int HALF_DIV = 2;
    localparam int GAIN     = 4;
    localparam int FRAME_CLK = 128 * HALF_DIV;

    logic clock;
    logic resetN;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];
    bit          monEnable = 0;

    ts_i2s_tx_if ifc();

    ts_i2s_tx #(
        .CLK_HALF_DIV (HALF_DIV),
        .GAIN_SHIFT   (GAIN)
    ) dut (
        .CLK     (clock),
        .RESET_N (resetN),
        .bus     (ifc)
    );

    // Free-running system clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference conversion written arithmetically: signed value times the gain, truncated to 16 bits.
    function automatic logic [15:0] modelConv(input logic [11:0] x, input logic sgn, input logic mute);
        int v;
        if (mute) return 16'h0000;
        if (sgn) v = int'($signed(x));
        else     v = int'(x) - 2048;
        v = v * (1 << GAIN);
        return v[15:0];
    endfunction

    // Wait for the next SAMPLE_STB pulse, sampled on the falling system clock edge.
    task automatic waitStb();
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < 3 * FRAME_CLK) begin
            @(negedge clock);
            n++;
            if (ifc.SAMPLE_STB) seen = 1;
        end
        if (!seen) checkOutput("stbTimeout", 32'd0, 32'd1);
    endtask

    // Wait for a number of BCLK falling transitions.
    task automatic waitBclkFalls(input int count);
        int   n = 0;
        int   f = 0;
        logic p;
        p = ifc.I2S_BCLK;
        while (f < count && n < 8 * HALF_DIV * (count + 2)) begin
            @(negedge clock);
            n++;
            if (p && !ifc.I2S_BCLK) f++;
            p = ifc.I2S_BCLK;
        end
        if (f < count) checkOutput("bclkFallTimeout", 32'(f), 32'(count));
    endtask

    // Wait for a rising edge of BCLK (sel=0) or LRCK (sel=1); returns cycles spent waiting.
    task automatic waitRise(input int sel, output int cycles);
        int   n    = 0;
        bit   seen = 0;
        logic p, c;
        p = sel ? ifc.I2S_LRCK : ifc.I2S_BCLK;
        while (!seen && n < 3 * FRAME_CLK) begin
            @(negedge clock);
            n++;
            c = sel ? ifc.I2S_LRCK : ifc.I2S_BCLK;
            if (c && !p) seen = 1;
            p = c;
        end
        if (!seen) checkOutput("riseTimeout", 32'd0, 32'd1);
        cycles = n;
    endtask

    // Drive a new input set mid-frame (optionally holdBits BCLKs into the frame) and
    // expect it on each of the next 'frames' frame starts.
    task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r, input logic sgn,
                                 input logic mute, input int holdBits, input int frames);
        if (holdBits > 0) waitBclkFalls(holdBits);
        ifc.IN_L      = l;
        ifc.IN_R      = r;
        ifc.IN_SIGNED = sgn;
        ifc.MUTE      = mute;
        for (int i = 0; i < frames; i++)
            sb.push_back({modelConv(l, sgn, mute), modelConv(r, sgn, mute)});
        for (int i = 0; i < frames; i++)
            waitStb();
    endtask

    // DAC model: samples SDATA on BCLK rises, rebuilds both words and checks the zero slots.
    int          slot    = 0;
    int          zeroErr = 0;
    bit          started = 0;
    logic        prevBclk = 0;
    logic        prevLrck = 0;
    logic [15:0] word    = '0;
    logic [15:0] gotL    = '0;
    logic [31:0] expWord;

    always @(negedge clock) begin
        if (!resetN) begin
            started  = 0;
            prevBclk = 0;
            prevLrck = 0;
            slot     = 0;
        end else begin
            if (ifc.I2S_BCLK && !prevBclk) begin
                if (ifc.I2S_LRCK != prevLrck) slot = 0;
                else                          slot = slot + 1;
                if (!ifc.I2S_LRCK && prevLrck && monEnable) begin
                    started = 1;
                    zeroErr = 0;
                end
                if (started) begin
                    if (slot >= 1 && slot <= 16) word = {word[14:0], ifc.I2S_SDATA};
                    else if (ifc.I2S_SDATA)      zeroErr++;
                    if (slot == 31 && !ifc.I2S_LRCK) gotL = word;
                    if (slot == 31 && ifc.I2S_LRCK) begin
                        if (sb.size() == 0) begin
                            checkOutput("sbEmpty", 32'd1, 32'd0);
                        end else begin
                            expWord = sb.pop_front();
                            checkOutput("leftWord", 32'(gotL), 32'(expWord[31:16]));
                            checkOutput("rightWord", 32'(word), 32'(expWord[15:0]));
                            checkOutput("zeroSlots", 32'(zeroErr), 32'd0);
                        end
                        zeroErr = 0;
                    end
                end
                prevLrck = ifc.I2S_LRCK;
            end
            prevBclk = ifc.I2S_BCLK;
        end
    end

    // Wait until every expected frame has been decoded.
    task automatic drainScoreboard();
        int n = 0;
        while (sb.size() != 0 && n < 3 * FRAME_CLK) begin
            @(negedge clock);
            n++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    int cyc;
    int width;
    bit seenLow;
    bit done;

    initial begin
        ifc.IN_L      = 12'h000;
        ifc.IN_R      = 12'h000;
        ifc.IN_SIGNED = 1'b1;
        ifc.MUTE      = 1'b0;
        resetN        = 1'b0;
        #1;
        checkOutput("rstBclk", 32'(ifc.I2S_BCLK), 32'd0);
        checkOutput("rstLrck", 32'(ifc.I2S_LRCK), 32'd0);
        checkOutput("rstSdata", 32'(ifc.I2S_SDATA), 32'd0);
        checkOutput("rstStb", 32'(ifc.SAMPLE_STB), 32'd0);
        repeat (3) @(negedge clock);
        resetN = 1'b1;

        // Idle timing: BCLK period, LRCK period, strobe width and spacing.
        waitRise(0, cyc);
        waitRise(0, cyc);
        checkOutput("bclkPeriod", 32'(cyc), 32'(2 * HALF_DIV));
        waitRise(1, cyc);
        waitRise(1, cyc);
        checkOutput("lrckPeriod", 32'(cyc), 32'(FRAME_CLK));
        waitStb();
        cyc = 0; width = 1; seenLow = 0; done = 0;
        while (!done && cyc < 3 * FRAME_CLK) begin
            @(negedge clock);
            cyc++;
            if (ifc.SAMPLE_STB) begin
                if (!seenLow) width++;
                else          done = 1;
            end else begin
                seenLow = 1;
            end
        end
        checkOutput("stbWidth", 32'(width), 32'd1);
        checkOutput("stbPeriod", 32'(cyc), 32'(FRAME_CLK));

        repeat (8) @(negedge clock);
        monEnable = 1;

        // Data frames: signed/offset extremes, mute timing, late input change, random words.
        applyStimulus(12'h7FF, 12'h800, 1'b1, 1'b0, 0, 2);
        applyStimulus(12'h800, 12'hFFF, 1'b0, 1'b0, 0, 1);
        applyStimulus(12'h123, 12'hABC, 1'b1, 1'b0, 0, 1);
        applyStimulus(12'h123, 12'hABC, 1'b1, 1'b1, 16, 1);
        applyStimulus(12'h123, 12'hABC, 1'b1, 1'b0, 0, 1);
        applyStimulus(12'h100, 12'h055, 1'b1, 1'b0, 0, 1);
        applyStimulus(12'h200, 12'h055, 1'b1, 1'b0, 40, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                          1'($urandom_range(0, 1)), 1'b0, 0, 1);
        drainScoreboard();

        // Reset at bit 20 with BCLK high: outputs clear immediately, frame restarts from scratch.
        waitStb();
        waitBclkFalls(20);
        waitRise(0, cyc);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midRstBclk", 32'(ifc.I2S_BCLK), 32'd0);
        checkOutput("midRstLrck", 32'(ifc.I2S_LRCK), 32'd0);
        checkOutput("midRstSdata", 32'(ifc.I2S_SDATA), 32'd0);
        checkOutput("midRstStb", 32'(ifc.SAMPLE_STB), 32'd0);
        ifc.IN_L      = 12'h3C5;
        ifc.IN_R      = 12'h0A0;
        ifc.IN_SIGNED = 1'b1;
        ifc.MUTE      = 1'b0;
        sb.push_back({modelConv(12'h3C5, 1'b1, 1'b0), modelConv(12'h0A0, 1'b1, 1'b0)});
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 4 * FRAME_CLK) begin
            @(negedge clock);
            cyc++;
            if (ifc.SAMPLE_STB) done = 1;
        end
        checkOutput("stbAfterReset", 32'(cyc), 32'(FRAME_CLK));
        drainScoreboard();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
